// File: rtl/combi_pkg.sv
// Shared types and constants for the combined ARM/RISC-V pipeline front end.
package combi_pkg;

   localparam int unsigned PC_W = 32;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_HOLD,
      F_DROP
   } fetch_state_t;

   // Word-align an address by clearing the two byte-offset bits.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/combi_fetch_buffer.sv
// One-entry skid register that parks a fetched word while decode is stalled.
module combi_fetch_buffer
   import combi_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            drain,
   input  logic            clear,
   input  logic [31:0]     load_instr,
   input  logic [PC_W-1:0] load_pc,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] pc
);

   logic            valid_q;
   logic [31:0]     instr_q;
   logic [PC_W-1:0] pc_q;

   // Clear and drain empty the entry; load captures a word and its PC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else if (clear || drain) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         instr_q <= load_instr;
         pc_q    <= load_pc;
      end
   end

   assign valid = valid_q;
   assign instr = instr_q;
   assign pc    = pc_q;

endmodule

// File: rtl/combi_fetch_stage.sv
// Fetch stage: owns the PC, runs a single-outstanding instruction memory handshake
// and holds the IF/ID pipeline register feeding decode.
module combi_fetch_stage
   import combi_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic        RESET_ARM = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   input  logic [31:0] ImemRData,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        armD,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic [31:0] PCPlus8D,
   output logic        ValidD,
   output logic        wasNotFlushed,
   output logic        armIn
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] addr_q, addr_d;
   logic [PC_W-1:0] target;

   logic            load_direct;
   logic            load_buf;
   logic            buf_load;
   logic            buf_drain;
   logic            buf_clear;
   logic            buf_valid;
   logic [31:0]     buf_instr;
   logic [PC_W-1:0] buf_pc;

   logic            id_load;
   logic [31:0]     id_load_instr;
   logic [PC_W-1:0] id_load_pc;

   logic [31:0]     instr_q;
   logic [PC_W-1:0] pc_q;
   logic            valid_q;
   logic            not_flushed_q;
   logic            arm_q;

   assign target = align_pc(PCTargetE);

   // Next fetch state, next PC and the IF/ID / skid-buffer controls.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      load_direct = 1'b0;
      load_buf    = 1'b0;
      buf_load    = 1'b0;
      buf_drain   = 1'b0;
      buf_clear   = 1'b0;
      unique case (state_q)
         F_IDLE: begin
            state_d = F_REQ;
         end
         F_REQ: begin
            if (!ImemAck) begin
               if (PCSrcE) begin
                  // Request must stay up on the old address; its reply is thrown away.
                  state_d    = F_DROP;
                  fetch_pc_d = target;
               end
            end else if (PCSrcE) begin
               fetch_pc_d = target;
            end else if (StallD) begin
               buf_load = 1'b1;
               state_d  = F_HOLD;
            end else begin
               load_direct = 1'b1;
               fetch_pc_d  = fetch_pc_q + 32'd4;
            end
         end
         F_HOLD: begin
            if (PCSrcE) begin
               buf_clear  = 1'b1;
               fetch_pc_d = target;
               state_d    = F_REQ;
            end else if (!StallD) begin
               load_buf   = buf_valid;
               buf_drain  = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = F_REQ;
            end
         end
         F_DROP: begin
            if (PCSrcE) begin
               fetch_pc_d = target;
            end
            if (ImemAck) begin
               state_d = F_REQ;
            end
         end
         default: begin
            state_d = F_IDLE;
         end
      endcase
      // The presented address only freezes while a stale request is outstanding.
      addr_d = (state_d == F_DROP) ? addr_q : fetch_pc_d;
   end

   // Fetch state, PC and presented address registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= F_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end

   combi_fetch_buffer u_buffer (
      .clk        (clk),
      .reset      (reset),
      .load       (buf_load),
      .drain      (buf_drain),
      .clear      (buf_clear),
      .load_instr (ImemRData),
      .load_pc    (fetch_pc_q),
      .valid      (buf_valid),
      .instr      (buf_instr),
      .pc         (buf_pc)
   );

   assign id_load       = load_direct || load_buf;
   assign id_load_instr = load_buf ? buf_instr : ImemRData;
   assign id_load_pc    = load_buf ? buf_pc : fetch_pc_q;

   // IF/ID register: flush beats stall, stall beats load, otherwise insert a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q       <= '0;
         pc_q          <= RESET_PC;
         valid_q       <= 1'b0;
         not_flushed_q <= 1'b0;
      end else if (FlushD) begin
         instr_q       <= '0;
         valid_q       <= 1'b0;
         not_flushed_q <= 1'b0;
      end else if (!StallD) begin
         if (id_load) begin
            instr_q       <= id_load_instr;
            pc_q          <= id_load_pc;
            valid_q       <= 1'b1;
            not_flushed_q <= 1'b1;
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   // ISA mode is captured as an instruction leaves decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arm_q <= RESET_ARM;
      end else if (valid_q && not_flushed_q && !StallD && !FlushD) begin
         arm_q <= armD;
      end
   end

   assign ImemReq       = (state_q == F_REQ) || (state_q == F_DROP);
   assign ImemAddr      = addr_q;
   assign InstrD        = instr_q;
   assign PCD           = pc_q;
   assign PCPlus4D      = pc_q + 32'd4;
   assign PCPlus8D      = pc_q + 32'd8;
   assign ValidD        = valid_q;
   assign wasNotFlushed = not_flushed_q;
   assign armIn         = arm_q;

endmodule

// File: tb/tb_combi_fetch_stage.sv
// Self-checking bench for combi_fetch_stage with a behavioural memory and stream model.
module tb_combi_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ImemReq, ImemAck, PCSrcE, StallD, FlushD, armD;
   logic        ValidD, wasNotFlushed, armIn;
   logic [31:0] ImemAddr, ImemRData, PCTargetE, InstrD, PCD, PCPlus4D, PCPlus8D;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned mem_lat  = 0;
   int unsigned wait_cnt = 0;
   bit          rand_lat = 1'b0;
   logic [31:0] salt     = 32'h0;

   always #5 clk = ~clk;

   combi_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .ImemReq       (ImemReq),
      .ImemAddr      (ImemAddr),
      .ImemAck       (ImemAck),
      .ImemRData     (ImemRData),
      .PCSrcE        (PCSrcE),
      .PCTargetE     (PCTargetE),
      .StallD        (StallD),
      .FlushD        (FlushD),
      .armD          (armD),
      .InstrD        (InstrD),
      .PCD           (PCD),
      .PCPlus4D      (PCPlus4D),
      .PCPlus8D      (PCPlus8D),
      .ValidD        (ValidD),
      .wasNotFlushed (wasNotFlushed),
      .armIn         (armIn)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ salt;
   endfunction

   // Memory model: acks a request after mem_lat waiting cycles.
   task automatic drive_mem();
      if (ImemReq) begin
         if (wait_cnt >= mem_lat) begin
            ImemAck   = 1'b1;
            ImemRData = word(ImemAddr);
            wait_cnt  = 0;
            if (rand_lat) mem_lat = $urandom_range(0, 3);
         end else begin
            ImemAck   = 1'b0;
            ImemRData = $urandom;
            wait_cnt++;
         end
      end else begin
         ImemAck   = 1'b0;
         ImemRData = $urandom;
         wait_cnt  = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0; FlushD = 1'b0;
      armD = 1'b0; ImemAck = 1'b0; ImemRData = '0; wait_cnt = 0; rand_lat = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      salt = 32'h0;
      mem_lat = 0;
      do_reset();
      n_checks++;
      if (ImemReq !== 1'b0 || ImemAddr !== 32'h0 || InstrD !== 32'h0 || PCD !== 32'h0 ||
          ValidD !== 1'b0 || wasNotFlushed !== 1'b0 || armIn !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values req=%b addr=%h instr=%h pc=%h valid=%b wnf=%b arm=%b",
                  ImemReq, ImemAddr, InstrD, PCD, ValidD, wasNotFlushed, armIn);
      end
      drive_mem();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (ImemReq !== 1'b1 || ImemAddr !== 32'(4 * k)) begin
            n_fail++;
            $display("FAIL reset_stream_addr k=%0d got req=%b addr=%h want addr=%h",
                     k, ImemReq, ImemAddr, 32'(4 * k));
         end
         if (k >= 1) begin
            n_checks++;
            if (ValidD !== 1'b1 || PCD !== 32'(4 * (k - 1)) || InstrD !== 32'(4 * (k - 1)) ||
                PCPlus8D !== 32'(4 * (k - 1) + 8)) begin
               n_fail++;
               $display("FAIL reset_stream_id k=%0d got v=%b pc=%h instr=%h pc8=%h want pc=%h",
                        k, ValidD, PCD, InstrD, PCPlus8D, 32'(4 * (k - 1)));
            end
         end
         drive_mem();
      end
   endtask

   task automatic test_wait_state();
      logic [31:0] expc, prev_addr;
      logic        prev_req, prev_ack, prev_valid, seen;
      int          pulses;
      salt = 32'h5A5A_1234;
      mem_lat = 3;
      do_reset();
      drive_mem();
      expc = 0; prev_req = 0; prev_ack = 0; prev_addr = 0; prev_valid = 0; seen = 0; pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (prev_req && !prev_ack) begin
            n_checks++;
            if (ImemReq !== 1'b1 || ImemAddr !== prev_addr) begin
               n_fail++;
               $display("FAIL wait_addr_stable got req=%b addr=%h want addr=%h",
                        ImemReq, ImemAddr, prev_addr);
            end
         end
         if (ValidD) begin
            n_checks++;
            if (PCD !== expc || InstrD !== word(expc) || prev_valid) begin
               n_fail++;
               $display("FAIL wait_fetch got pc=%h instr=%h prev_valid=%b want pc=%h instr=%h",
                        PCD, InstrD, prev_valid, expc, word(expc));
            end
            expc += 4;
            pulses++;
            seen = 1'b1;
         end else if (seen) begin
            n_checks++;
            if (wasNotFlushed !== 1'b1) begin
               n_fail++;
               $display("FAIL wait_bubble_wnf got %b want 1", wasNotFlushed);
            end
         end
         prev_valid = ValidD;
         prev_req   = ImemReq;
         prev_addr  = ImemAddr;
         drive_mem();
         prev_ack   = ImemAck;
      end
      n_checks++;
      if (pulses != 9) begin
         n_fail++;
         $display("FAIL wait_pulse_count got %0d want 9", pulses);
      end
   endtask

   task automatic test_stall();
      logic [31:0] expc;
      int          stall_left, after_rel;
      bit          stalled_once;
      salt = 32'h0BAD_F00D;
      mem_lat = 0;
      do_reset();
      drive_mem();
      expc = 0; stall_left = 0; after_rel = -1; stalled_once = 0;
      repeat (25) begin
         @(negedge clk);
         if (after_rel == 1) begin
            n_checks++;
            if (InstrD !== word(32'h10) || PCD !== 32'h10 || ImemReq !== 1'b1 ||
                ImemAddr !== 32'h14) begin
               n_fail++;
               $display("FAIL stall_release got instr=%h pc=%h req=%b addr=%h want pc=10 addr=14",
                        InstrD, PCD, ImemReq, ImemAddr);
            end
         end
         if (after_rel >= 0) after_rel++;
         if (!stalled_once && ImemReq && ImemAddr == 32'h10) begin
            stall_left = 4;
            stalled_once = 1'b1;
         end else if (stall_left > 0) begin
            n_checks++;
            if (ImemReq !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_hold_req got %b want 0", ImemReq);
            end
            if (stall_left == 1) after_rel = 0;
         end
         StallD = (stall_left > 0);
         if (stall_left > 0) stall_left--;
         if (ValidD && wasNotFlushed && !StallD) begin
            n_checks++;
            if (PCD !== expc || InstrD !== word(expc)) begin
               n_fail++;
               $display("FAIL stall_stream got pc=%h instr=%h want pc=%h instr=%h",
                        PCD, InstrD, expc, word(expc));
            end
            expc += 4;
         end
         drive_mem();
      end
      StallD = 1'b0;
      n_checks++;
      if (!stalled_once || expc < 32'h30) begin
         n_fail++;
         $display("FAIL stall_progress got next_pc=%h stalled=%b want >=30", expc, stalled_once);
      end
   endtask

   task automatic test_redirect_wait();
      bit redirected, addr_checked, found;
      salt = 32'h1357_9BDF;
      mem_lat = 3;
      do_reset();
      drive_mem();
      redirected = 0; addr_checked = 0; found = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (ValidD && PCD == 32'h20) begin
            n_checks++;
            n_fail++;
            $display("FAIL redirect_dropped got pc=%h valid, want dropped", PCD);
         end
         if (!redirected) begin
            if (ImemReq && ImemAddr == 32'h20) begin
               PCSrcE = 1'b1; PCTargetE = 32'h103; FlushD = 1'b1; redirected = 1'b1;
            end
         end else begin
            PCSrcE = 1'b0; FlushD = 1'b0;
            if (ImemReq && ImemAddr !== 32'h20 && !addr_checked) begin
               addr_checked = 1'b1;
               n_checks++;
               if (ImemAddr !== 32'h100) begin
                  n_fail++;
                  $display("FAIL redirect_addr got %h want 00000100", ImemAddr);
               end
            end
            if (ValidD) begin
               found = 1'b1;
               n_checks++;
               if (PCD !== 32'h100 || InstrD !== word(32'h100)) begin
                  n_fail++;
                  $display("FAIL redirect_first got pc=%h instr=%h want pc=100 instr=%h",
                           PCD, InstrD, word(32'h100));
               end
            end
         end
         drive_mem();
         if (found) break;
      end
      n_checks++;
      if (!found || !addr_checked) begin
         n_fail++;
         $display("FAIL redirect_timeout got found=%b addr_seen=%b want 1 1", found, addr_checked);
      end
   endtask

   task automatic test_flush();
      logic [31:0] pc_before;
      bit          got;
      salt = 32'hCAFE_0000;
      mem_lat = 0;
      do_reset();
      drive_mem();
      got = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ValidD) begin
            got = 1'b1;
            break;
         end
         drive_mem();
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL flush_no_valid got 0 want 1");
      end
      pc_before = PCD;
      FlushD = 1'b1; armD = 1'b1;
      drive_mem();
      @(negedge clk);
      n_checks++;
      if (wasNotFlushed !== 1'b0 || ValidD !== 1'b0 || InstrD !== 32'h0 || armIn !== 1'b0 ||
          PCD !== pc_before) begin
         n_fail++;
         $display("FAIL flush_state got wnf=%b v=%b instr=%h arm=%b pc=%h want 0 0 0 0 %h",
                  wasNotFlushed, ValidD, InstrD, armIn, PCD, pc_before);
      end
      FlushD = 1'b0;
      drive_mem();
      @(negedge clk);
      n_checks++;
      if (ValidD !== 1'b1 || wasNotFlushed !== 1'b1 || armIn !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_next_valid got v=%b wnf=%b arm=%b want 1 1 0",
                  ValidD, wasNotFlushed, armIn);
      end
      drive_mem();
      @(negedge clk);
      n_checks++;
      if (armIn !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_arm_update got %b want 1", armIn);
      end
      armD = 1'b0;
   endtask

   task automatic test_wrap_reset();
      salt = 32'h7777_0000;
      mem_lat = 0;
      do_reset();
      drive_mem();
      @(negedge clk);
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; FlushD = 1'b1;
      drive_mem();
      @(negedge clk);
      PCSrcE = 1'b0; FlushD = 1'b0;
      n_checks++;
      if (ImemReq !== 1'b1 || ImemAddr !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_target got req=%b addr=%h want fffffffc", ImemReq, ImemAddr);
      end
      drive_mem();
      @(negedge clk);
      n_checks++;
      if (ImemAddr !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 ||
          PCPlus8D !== 32'h4 || ValidD !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_values got addr=%h pc=%h pc4=%h pc8=%h v=%b want 0 fffffffc 0 4 1",
                  ImemAddr, PCD, PCPlus4D, PCPlus8D, ValidD);
      end
      mem_lat = 3;
      drive_mem();
      @(negedge clk);
      #2;
      reset = 1'b0;
      ImemAck = 1'b0;
      #1;
      n_checks++;
      if (ImemReq !== 1'b0 || ImemAddr !== 32'h0 || InstrD !== 32'h0 || PCD !== 32'h0 ||
          ValidD !== 1'b0 || wasNotFlushed !== 1'b0 || armIn !== 1'b0) begin
         n_fail++;
         $display("FAIL midreq_reset got req=%b addr=%h instr=%h pc=%h v=%b wnf=%b arm=%b",
                  ImemReq, ImemAddr, InstrD, PCD, ValidD, wasNotFlushed, armIn);
      end
   endtask

   task automatic test_random();
      logic [31:0] expc, prev_addr;
      logic        prev_req, prev_ack, exp_arm, redirect;
      int          consumed;
      salt = $urandom;
      mem_lat = $urandom_range(0, 3);
      do_reset();
      rand_lat = 1'b1;
      drive_mem();
      expc = 0; prev_addr = 0; prev_req = 0; prev_ack = 0; exp_arm = 0; consumed = 0;
      repeat (3000) begin
         @(negedge clk);
         if (prev_req && !prev_ack) begin
            n_checks++;
            if (ImemReq !== 1'b1 || ImemAddr !== prev_addr) begin
               n_fail++;
               $display("FAIL rand_handshake got req=%b addr=%h want addr=%h",
                        ImemReq, ImemAddr, prev_addr);
            end
         end
         if (ImemReq) begin
            n_checks++;
            if (ImemAddr[1:0] !== 2'b00) begin
               n_fail++;
               $display("FAIL rand_align got addr=%h want low bits 00", ImemAddr);
            end
         end
         n_checks++;
         if (armIn !== exp_arm) begin
            n_fail++;
            $display("FAIL rand_arm got %b want %b", armIn, exp_arm);
         end
         redirect  = ($urandom_range(0, 19) == 0);
         PCSrcE    = redirect;
         FlushD    = redirect;
         PCTargetE = $urandom;
         StallD    = ($urandom_range(0, 3) == 0);
         armD      = 1'($urandom_range(0, 1));
         if (ValidD && wasNotFlushed && !StallD && !FlushD) begin
            n_checks++;
            if (PCD !== expc || InstrD !== word(expc) || PCPlus4D !== expc + 32'd4) begin
               n_fail++;
               $display("FAIL rand_stream got pc=%h instr=%h pc4=%h want pc=%h instr=%h",
                        PCD, InstrD, PCPlus4D, expc, word(expc));
            end
            expc += 4;
            consumed++;
            exp_arm = armD;
         end
         if (redirect) expc = {PCTargetE[31:2], 2'b00};
         prev_req  = ImemReq;
         prev_addr = ImemAddr;
         drive_mem();
         prev_ack  = ImemAck;
      end
      PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0; rand_lat = 1'b0;
      n_checks++;
      if (consumed < 300) begin
         n_fail++;
         $display("FAIL rand_progress got %0d consumed want >=300", consumed);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_wait_state();
      test_stall();
      test_redirect_wait();
      test_flush();
      test_wrap_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/combi_fetch_stage.md
# combi_fetch_stage

Fetch stage of the combined ARM/RISC-V pipeline, directly upstream of the decode stage. It owns the PC, runs a single-outstanding-request handshake to instruction memory, and holds the IF/ID pipeline register. It supplies the decoder with the instruction, the PC values, the flush indication, and the registered ISA mode of the previously decoded instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `RESET_ARM`, default 1'b0: ISA mode after reset (0 = RISC-V).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ImemReq`  out  1  fetch request.
- `ImemAddr`  out  32  fetch address; bits [1:0] are always 00.
- `ImemAck`  in  1  response valid; may assert in the same cycle as `ImemReq`.
- `ImemRData`  in  32  instruction word; valid only when `ImemAck`=1.
- `PCSrcE`  in  1  redirect request from execute (taken branch or jump).
- `PCTargetE`  in  32  redirect target; bits [1:0] are ignored.
- `StallD`  in  1  hold the IF/ID register.
- `FlushD`  in  1  invalidate the IF/ID register.
- `armD`  in  1  ISA resolved by the decoder for the current `InstrD`.
- `InstrD`  out  32  instruction to decode.
- `PCD`, `PCPlus4D`, `PCPlus8D`  out  32 each  PC of `InstrD`, PC+4, PC+8 (ARM R15 read value).
- `ValidD`  out  1  `InstrD` holds a real instruction.
- `wasNotFlushed`  out  1  `InstrD` was not flushed; feeds the decoder.
- `armIn`  out  1  ISA mode of the last instruction that left decode.

## Operation
- FSM states in `fetch_state_t`:
  - F_IDLE: `ImemReq`=0.
  - F_REQ: `ImemReq`=1, address = `FetchPC`.
  - F_HOLD: response buffered; `ImemReq`=0.
  - F_DROP: `ImemReq`=1, stale address; response will be discarded.
- Handshake rule: once `ImemReq` rises, `ImemAddr` stays stable and `ImemReq` stays high until the `ImemAck` cycle. At most one request is outstanding.
- F_IDLE -> F_REQ unconditionally.
- F_REQ, no `ImemAck`:
  - `PCSrcE` -> F_DROP; `FetchPC` <= target & ~3.
  - Otherwise stay in F_REQ.
- F_REQ, `ImemAck`, `PCSrcE`=1: discard the data; `FetchPC` <= target & ~3; stay in F_REQ.
- F_REQ, `ImemAck`, `PCSrcE`=0, `StallD`=1: data and `FetchPC` go to the skid buffer; -> F_HOLD.
- F_REQ, `ImemAck`, `PCSrcE`=0, `StallD`=0: load IF/ID directly; `FetchPC` += 4; stay in F_REQ.
- F_HOLD:
  - `PCSrcE` -> discard the buffer, `FetchPC` <= target, -> F_REQ.
  - Else if `StallD`=0 -> buffer loads IF/ID, `FetchPC` += 4, -> F_REQ.
- F_DROP:
  - On `ImemAck`: discard the data, -> F_REQ at the already-updated `FetchPC`.
  - A further `PCSrcE` while in F_DROP only updates `FetchPC`.
- IF/ID load: `InstrD`, `PCD` (plus +4/+8) take the loaded word and its PC; `ValidD`=1, `wasNotFlushed`=1.
- `FlushD` (priority over load and stall): `InstrD`=0, `ValidD`=0, `wasNotFlushed`=0. `PCD` is kept.
- `StallD` with no flush: IF/ID holds.
- No load and no stall: `ValidD`=0 (bubble); `wasNotFlushed` keeps its value.
- `armIn` <= `armD` when `ValidD`=1, `wasNotFlushed`=1, `StallD`=0 and `FlushD`=0; otherwise it holds.
- Arithmetic: all PC adds are 32-bit and wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset values: state F_IDLE, `ImemReq`=0, `ImemAddr`=`FetchPC`=`RESET_PC`, `InstrD`=0, `PCD`=`RESET_PC`, `ValidD`=0, `wasNotFlushed`=0, `armIn`=`RESET_ARM`.
- Reset asserted mid-request abandons the request; the memory must tolerate this.
- The first request goes out the cycle after reset release.
- Latency: `ImemAck` in cycle n gives `InstrD` valid in cycle n+1.
- With a zero-wait memory the stage sustains one instruction per cycle.
- A redirect in cycle n gives `ImemAddr`=target in cycle n+1 when no request is pending.
- `ImemReq` and `ImemAddr` are registered-state driven; there is no combinational path from `ImemAck` or `PCSrcE` to `ImemReq` or `ImemAddr`.

## Structure
- `combi_pkg` contains:
  - `fetch_state_t`.
  - `RV_NOP` = 32'h0000_0013.
  - PC width constant `PC_W` = 32.
- Sub-module `combi_fetch_buffer`: a one-entry skid register holding {instr, pc}, with load, drain and clear controls. It is instantiated once.

## Test plan
- **Reset release.** Release `reset` with `ImemAck` tied to 1 and `ImemRData` = address. Required: `ImemAddr` = 0, 4, 8 on consecutive cycles; `InstrD`/`PCD` follow one cycle later; `PCPlus8D` = `PCD` + 8.
- **Wait-state memory.** Ack only 3 cycles after each request. Required: `ImemAddr` stable while waiting; `ValidD` pulses once per fetch.
- **Stall.** `StallD`=1 for 4 cycles arriving with an ack at 0x10. Required: F_HOLD; `ImemReq`=0; after release `InstrD` = word@0x10, then 0x14 is fetched; no instruction is lost or duplicated.
- **Redirect while waiting.** `PCSrcE`, target 0x103 (low bits set), while a request to 0x20 is pending. Required: the 0x20 response is dropped; the next `ImemAddr` = 0x100.
- **Flush.** `FlushD` with `armD`=1. Required: `wasNotFlushed`=0, `ValidD`=0, `armIn` unchanged. Next valid instruction with `armD`=1 and no stall -> `armIn`=1 one cycle later.
- **Wrap and mid-request reset.** Start with `FetchPC`=0xFFFF_FFFC. Required: next address is 0. Assert `reset` mid-request: all outputs return to reset values immediately.
